wbuart_tx_buffer: RTL

Wishbone-slave UART transmit front end with a circular byte FIFO.
- The CPU writes bytes without stalling on the serial line.
- A drain state machine feeds the buffered bytes, one at a time, to a downstream UART transmitter using the o_tx_data/o_tx_stb/i_tx_busy handshake.
- Sits on the IO Wishbone bus as the transmit-side counterpart of the buffered RX path.

---
 rtl/wbuart_pkg.sv | 23 ++
 rtl/wbuart_tx_buffer_if.sv | 23 ++
 rtl/tx_byte_fifo.sv | 54 +++++
 rtl/wbuart_tx_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wbuart_pkg.sv
// Shared constants and state types for the wbuart transmit buffer.
package wbuart_pkg;

   localparam logic ADDR_CTRL = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   localparam int unsigned CTRL_OVERRUN = 31;
   localparam int unsigned CTRL_CTS     = 30;
   localparam int unsigned CTRL_EMPTY   = 29;
   localparam int unsigned CTRL_FLUSH   = 0;

   typedef enum logic {
      WB_IDLE,
      WB_ACK
   } wb_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_STROBE,
      TX_WAIT
   } tx_state_e;

endpackage

// File: rtl/wbuart_tx_buffer_if.sv
// Wishbone slave bus bundle for the wbuart transmit buffer.
interface wbuart_tx_buffer_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [3:0]  i_wb_sel;
   logic [29:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic        o_wb_err;
   logic [31:0] o_wb_data;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
      output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
      input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
   );
endinterface

// File: rtl/tx_byte_fifo.sv
// Circular byte FIFO: one-bit-wider pointers so all 2**DEPTH_LOG2 entries are usable.
module tx_byte_fifo #(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  push_i,
   input  logic [7:0]            push_data_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic [7:0]            rd_data_c,
   output logic [DEPTH_LOG2:0]   level_c,
   output logic                  full_c,
   output logic                  empty_c
);
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;

   // Flush overrides any concurrent push or pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + PTR_W'(1);
         if (pop_i)  rd_d = rd_q + PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_i) mem[wr_q[DEPTH_LOG2-1:0]] <= push_data_i;
   end

   assign rd_data_c = mem[rd_q[DEPTH_LOG2-1:0]];
   assign level_c   = wr_q - rd_q;
   assign full_c    = (level_c == PTR_W'(DEPTH));
   assign empty_c   = (level_c == '0);
endmodule

// File: rtl/wbuart_tx_buffer.sv
// Wishbone UART transmit front end: CPU-side byte FIFO drained into a busy/strobe transmitter.
// Optional macro WBUART_TX_CTS_EN adds an i_cts_n flow-control input.
module wbuart_tx_buffer
   import wbuart_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic              i_clk,
   input  logic              i_reset,
   wbuart_tx_buffer_if.slave wb,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_stb,
   input  logic              i_tx_busy
`ifdef WBUART_TX_CTS_EN
   ,
   input  logic              i_cts_n
`endif
);
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   wb_state_e        wb_state_q, wb_state_d;
   tx_state_e        tx_state_q, tx_state_d;
   logic             wb_ack_q, wb_ack_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_stb_q, tx_stb_d;
   logic             push_c, pop_c, flush_c;
   logic [7:0]       rd_data_c;
   logic [LVL_W-1:0] level_c;
   logic             full_c, empty_c;
   logic             cts_ok_c, cts_bit_c;
   logic [31:0]      ctrl_c;
   logic             unused_c;

`ifdef WBUART_TX_CTS_EN
   logic [1:0] cts_n_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) cts_n_q <= 2'b11;
      else         cts_n_q <= {cts_n_q[0], i_cts_n};
   end

   assign cts_ok_c  = ~cts_n_q[1];
   assign cts_bit_c = ~cts_n_q[1];
`else
   assign cts_ok_c  = 1'b1;
   assign cts_bit_c = 1'b0;
`endif

   tx_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .push_i      (push_c),
      .push_data_i (wb.i_wb_data[7:0]),
      .pop_i       (pop_c),
      .flush_i     (flush_c),
      .rd_data_c   (rd_data_c),
      .level_c     (level_c),
      .full_c      (full_c),
      .empty_c     (empty_c)
   );

   always_comb begin
      ctrl_c               = '0;
      ctrl_c[CTRL_OVERRUN] = ovf_q;
      ctrl_c[CTRL_CTS]     = cts_bit_c;
      ctrl_c[CTRL_EMPTY]   = empty_c;
      ctrl_c[LVL_W-1:0]    = level_c;
   end

   // Bus FSM: register side effects commit in the accept cycle, ack follows one cycle later.
   always_comb begin
      wb_state_d = wb_state_q;
      wb_ack_d   = 1'b0;
      wb_data_d  = '0;
      ovf_d      = ovf_q;
      push_c     = 1'b0;
      flush_c    = 1'b0;
      case (wb_state_q)
         WB_IDLE: begin
            if (wb.i_wb_cyc && wb.i_wb_stb) begin
               wb_state_d = WB_ACK;
               wb_ack_d   = 1'b1;
               if (wb.i_wb_we) begin
                  if (wb.i_wb_addr[0] == ADDR_DATA) begin
                     if (full_c) ovf_d  = 1'b1;
                     else        push_c = 1'b1;
                  end else begin
                     flush_c = wb.i_wb_data[CTRL_FLUSH];
                     if (wb.i_wb_data[CTRL_OVERRUN]) ovf_d = 1'b0;
                  end
               end else if (wb.i_wb_addr[0] == ADDR_CTRL) begin
                  wb_data_d = ctrl_c;
               end
            end
         end
         WB_ACK:  wb_state_d = WB_IDLE;
         default: wb_state_d = WB_IDLE;
      endcase
      if (!wb.i_wb_cyc) wb_state_d = WB_IDLE;
   end

   // Drain FSM: the guard cycles let the transmitter raise busy before the next decision.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_stb_d   = 1'b0;
      tx_data_d  = tx_data_q;
      pop_c      = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!empty_c && !i_tx_busy && cts_ok_c) begin
               tx_state_d = TX_STROBE;
               tx_stb_d   = 1'b1;
               tx_data_d  = rd_data_c;
               pop_c      = 1'b1;
            end
         end
         TX_STROBE: tx_state_d = TX_WAIT;
         TX_WAIT:   tx_state_d = TX_IDLE;
         default:   tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wb_state_q <= WB_IDLE;
         tx_state_q <= TX_IDLE;
         wb_ack_q   <= 1'b0;
         wb_data_q  <= '0;
         ovf_q      <= 1'b0;
         tx_data_q  <= '0;
         tx_stb_q   <= 1'b0;
      end else begin
         wb_state_q <= wb_state_d;
         tx_state_q <= tx_state_d;
         wb_ack_q   <= wb_ack_d;
         wb_data_q  <= wb_data_d;
         ovf_q      <= ovf_d;
         tx_data_q  <= tx_data_d;
         tx_stb_q   <= tx_stb_d;
      end
   end

   // An abandoned cycle gets no ack even though its write already committed.
   assign wb.o_wb_ack   = wb_ack_q & wb.i_wb_cyc;
   assign wb.o_wb_stall = (wb_state_q != WB_IDLE);
   assign wb.o_wb_err   = 1'b0;
   assign wb.o_wb_data  = wb_data_q;
   assign o_tx_data     = tx_data_q;
   assign o_tx_stb      = tx_stb_q;

   assign unused_c = ^{wb.i_wb_sel, wb.i_wb_addr[29:1], wb.i_wb_data[30:8]};
endmodule
